// File: rtl/gfx_pkg.sv
// Shared types for the rasterizer pixel-write responder and its clip helper.
// The optional statistics counters are enabled by defining GFX_CLIP_STATS_EN.
package gfx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ACK  = 2'd2
  } clip_state_e;

  localparam int unsigned POINT_WIDTH_DEF = 32'd16;
  localparam int unsigned CNT_WIDTH_DEF   = 32'd32;

endpackage

// File: rtl/gfx_clip_test.sv
// Combinational inside test: pixel must lie on the target surface and, when
// clipping is enabled, inside the half-open clip rectangle [x0,x1) x [y0,y1).
module gfx_clip_test
  import gfx_pkg::*;
#(
  parameter int unsigned point_width = POINT_WIDTH_DEF
) (
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  input  logic                   clipping_enable_i,
  input  logic [point_width-1:0] clip_x0_i,
  input  logic [point_width-1:0] clip_y0_i,
  input  logic [point_width-1:0] clip_x1_i,
  input  logic [point_width-1:0] clip_y1_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  output logic                   inside_o
);

  logic in_target_s;
  logic in_clip_s;

  // Empty rectangles and zero-sized targets fall out naturally as "never inside".
  assign in_target_s = (x_i < target_size_x_i) & (y_i < target_size_y_i);
  assign in_clip_s   = (x_i >= clip_x0_i) & (x_i < clip_x1_i) &
                       (y_i >= clip_y0_i) & (y_i < clip_y1_i);
  assign inside_o    = in_target_s & (~clipping_enable_i | in_clip_s);

endmodule

// File: rtl/gfx_clip_responder.sv
// Responder end of the rasterizer pixel-write handshake: drops clipped pixels,
// forwards the rest to the fragment stage. Statistics ports: GFX_CLIP_STATS_EN.
module gfx_clip_responder
  import gfx_pkg::*;
#(
  parameter int unsigned point_width = POINT_WIDTH_DEF
`ifdef GFX_CLIP_STATS_EN
  ,
  parameter int unsigned cnt_width   = CNT_WIDTH_DEF
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   write_i,
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  output logic                   ack_o,
  input  logic                   clipping_enable_i,
  input  logic [point_width-1:0] clip_x0_i,
  input  logic [point_width-1:0] clip_y0_i,
  input  logic [point_width-1:0] clip_x1_i,
  input  logic [point_width-1:0] clip_y1_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  output logic                   frag_write_o,
  output logic [point_width-1:0] frag_x_o,
  output logic [point_width-1:0] frag_y_o,
  output logic [point_width-1:0] frag_u_o,
  output logic [point_width-1:0] frag_v_o,
  input  logic                   frag_ack_i,
`ifdef GFX_CLIP_STATS_EN
  input  logic                   stats_clr_i,
  output logic [cnt_width-1:0]   pass_count_o,
  output logic [cnt_width-1:0]   discard_count_o,
`endif
  output logic                   busy_o
);

  clip_state_e            state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   frag_write_q, frag_write_d;
  logic                   busy_q, busy_d;
  logic [point_width-1:0] frag_x_q, frag_x_d;
  logic [point_width-1:0] frag_y_q, frag_y_d;
  logic [point_width-1:0] frag_u_q, frag_u_d;
  logic [point_width-1:0] frag_v_q, frag_v_d;
  logic                   inside_s;

  gfx_clip_test #(
    .point_width (point_width)
  ) u_clip_test (
    .x_i               (x_i),
    .y_i               (y_i),
    .clipping_enable_i (clipping_enable_i),
    .clip_x0_i         (clip_x0_i),
    .clip_y0_i         (clip_y0_i),
    .clip_x1_i         (clip_x1_i),
    .clip_y1_i         (clip_y1_i),
    .target_size_x_i   (target_size_x_i),
    .target_size_y_i   (target_size_y_i),
    .inside_o          (inside_s)
  );

  // Next-state and output decode; ACK is a one-cycle guard where write_i is ignored.
  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    frag_write_d = frag_write_q;
    frag_x_d     = frag_x_q;
    frag_y_d     = frag_y_q;
    frag_u_d     = frag_u_q;
    frag_v_d     = frag_v_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          frag_x_d = x_i;
          frag_y_d = y_i;
          frag_u_d = u_i;
          frag_v_d = v_i;
          if (inside_s) begin
            state_d      = FWD;
            frag_write_d = 1'b1;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FWD: begin
        if (frag_ack_i) begin
          state_d      = ACK;
          frag_write_d = 1'b0;
          ack_d        = 1'b1;
        end else begin
          frag_write_d = 1'b1;
        end
      end
      ACK: begin
        state_d      = IDLE;
        frag_write_d = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        frag_write_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      frag_write_q <= 1'b0;
      busy_q       <= 1'b0;
      frag_x_q     <= '0;
      frag_y_q     <= '0;
      frag_u_q     <= '0;
      frag_v_q     <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      frag_write_q <= frag_write_d;
      busy_q       <= busy_d;
      frag_x_q     <= frag_x_d;
      frag_y_q     <= frag_y_d;
      frag_u_q     <= frag_u_d;
      frag_v_q     <= frag_v_d;
    end
  end

  assign ack_o        = ack_q;
  assign frag_write_o = frag_write_q;
  assign busy_o       = busy_q;
  assign frag_x_o     = frag_x_q;
  assign frag_y_o     = frag_y_q;
  assign frag_u_o     = frag_u_q;
  assign frag_v_o     = frag_v_q;

`ifdef GFX_CLIP_STATS_EN
  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  logic                 pass_inc_s, discard_inc_s;
  logic [cnt_width-1:0] pass_q, pass_d, discard_q, discard_d;

  assign pass_inc_s    = (state_q == IDLE) & write_i & inside_s;
  assign discard_inc_s = (state_q == IDLE) & write_i & ~inside_s;

  // Saturating counters; a clear coinciding with an increment leaves a count of one.
  always_comb begin
    pass_d    = pass_q;
    discard_d = discard_q;
    if (stats_clr_i) begin
      pass_d    = pass_inc_s    ? CNT_ONE : '0;
      discard_d = discard_inc_s ? CNT_ONE : '0;
    end else begin
      if (pass_inc_s && (pass_q != '1)) begin
        pass_d = pass_q + CNT_ONE;
      end else begin
        pass_d = pass_q;
      end
      if (discard_inc_s && (discard_q != '1)) begin
        discard_d = discard_q + CNT_ONE;
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_q    <= '0;
      discard_q <= '0;
    end else begin
      pass_q    <= pass_d;
      discard_q <= discard_d;
    end
  end

  assign pass_count_o    = pass_q;
  assign discard_count_o = discard_q;
`endif

endmodule

// File: tb/tb_gfx_clip_responder.sv
// Self-checking bench for gfx_clip_responder: directed scenarios plus randomized
// pixels checked against a transaction-level reference model.
module tb_gfx_clip_responder;

  localparam int PW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          write_i;
  logic [PW-1:0] x_i, y_i, u_i, v_i;
  logic          ack_o;
  logic          clipping_enable_i;
  logic [PW-1:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
  logic [PW-1:0] target_size_x_i, target_size_y_i;
  logic          frag_write_o;
  logic [PW-1:0] frag_x_o, frag_y_o, frag_u_o, frag_v_o;
  logic          frag_ack_i;
  logic          busy_o;
`ifdef GFX_CLIP_STATS_EN
  logic          stats_clr_i;
  logic [31:0]   pass_count_o, discard_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  gfx_clip_responder #(.point_width(PW)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .write_i           (write_i),
    .x_i               (x_i),
    .y_i               (y_i),
    .u_i               (u_i),
    .v_i               (v_i),
    .ack_o             (ack_o),
    .clipping_enable_i (clipping_enable_i),
    .clip_x0_i         (clip_x0_i),
    .clip_y0_i         (clip_y0_i),
    .clip_x1_i         (clip_x1_i),
    .clip_y1_i         (clip_y1_i),
    .target_size_x_i   (target_size_x_i),
    .target_size_y_i   (target_size_y_i),
    .frag_write_o      (frag_write_o),
    .frag_x_o          (frag_x_o),
    .frag_y_o          (frag_y_o),
    .frag_u_o          (frag_u_o),
    .frag_v_o          (frag_v_o),
    .frag_ack_i        (frag_ack_i),
`ifdef GFX_CLIP_STATS_EN
    .stats_clr_i       (stats_clr_i),
    .pass_count_o      (pass_count_o),
    .discard_count_o   (discard_count_o),
`endif
    .busy_o            (busy_o)
  );

  // Reference rule: on-surface and (clipping off or inside the half-open rectangle).
  function automatic bit inside_ref(int x, int y, bit en, int x0, int y0,
                                    int x1, int y1, int tx, int ty);
    bit on_surface = (x < tx) && (y < ty);
    bit in_rect    = (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
    return on_surface && (!en || in_rect);
  endfunction

  task automatic set_cfg(input bit en, input int x0, input int y0, input int x1,
                         input int y1, input int tx, input int ty);
    clipping_enable_i = en;
    clip_x0_i = PW'(x0); clip_y0_i = PW'(y0);
    clip_x1_i = PW'(x1); clip_y1_i = PW'(y1);
    target_size_x_i = PW'(tx); target_size_y_i = PW'(ty);
  endtask

  // Drives one pixel and observes the transaction; cycle numbers count from the sampling edge.
  task automatic run_pixel(input int px, input int py, input int pu, input int pv,
                           input int ack_delay, input bit scramble,
                           output bit fwd, output int fx, output int fy, output int fu,
                           output int fv, output int frag_lat, output int ack_lat,
                           output bit ack_one, output bit stable);
    fwd = 1'b0; fx = 0; fy = 0; fu = 0; fv = 0;
    frag_lat = -1; ack_lat = -1; ack_one = 1'b0; stable = 1'b1;
    x_i = PW'(px); y_i = PW'(py); u_i = PW'(pu); v_i = PW'(pv);
    write_i = 1'b1; frag_ack_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk_i); #1;
      if (frag_write_o === 1'b1) begin
        if (!fwd) begin
          fwd = 1'b1; frag_lat = cyc;
          fx = int'(frag_x_o); fy = int'(frag_y_o); fu = int'(frag_u_o); fv = int'(frag_v_o);
        end else if (int'(frag_x_o) != fx || int'(frag_y_o) != fy ||
                     int'(frag_u_o) != fu || int'(frag_v_o) != fv) begin
          stable = 1'b0;
        end
        frag_ack_i = ((cyc - frag_lat) >= ack_delay);
      end else begin
        frag_ack_i = 1'b0;
      end
      if (ack_lat >= 0) begin
        ack_one = (ack_o === 1'b0);
        break;
      end
      if (ack_o === 1'b1) begin
        ack_lat = cyc;
        write_i = 1'b0;
      end else if (scramble && cyc == 1) begin
        x_i = PW'($urandom); y_i = PW'($urandom); u_i = PW'($urandom); v_i = PW'($urandom);
        write_i = 1'($urandom_range(0, 1));
        set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(0, 20));
      end
    end
    frag_ack_i = 1'b0;
    write_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; write_i = 1'b0; frag_ack_i = 1'b0;
    x_i = '0; y_i = '0; u_i = '0; v_i = '0;
`ifdef GFX_CLIP_STATS_EN
    stats_clr_i = 1'b0;
`endif
    set_cfg(1'b0, 0, 0, 0, 0, 640, 480);
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({ack_o, frag_write_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {ack_o, frag_write_o, busy_o});
    end
    n_checks++;
    if ({frag_x_o, frag_y_o, frag_u_o, frag_v_o} !== '0) begin
      n_fail++; $display("FAIL reset_coords: got %h %h %h %h expected all 0",
                         frag_x_o, frag_y_o, frag_u_o, frag_v_o);
    end
`ifdef GFX_CLIP_STATS_EN
    n_checks++;
    if (pass_count_o !== 32'd0 || discard_count_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", pass_count_o, discard_count_o);
    end
`endif
    rst_ni = 1'b1;
    frag_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (ack_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++; $display("FAIL stray_frag_ack: ack=%b busy=%b expected 0 0", ack_o, busy_o);
      end
    end
    frag_ack_i = 1'b0;
  endtask

  task automatic test_forward();
    bit fwd, one, stb; int fx, fy, fu, fv, fl, al;
    set_cfg(1'b0, 0, 0, 0, 0, 640, 480);
    run_pixel(10, 20, 3, 4, 3, 1'b0, fwd, fx, fy, fu, fv, fl, al, one, stb);
    n_checks++;
    if (fwd !== 1'b1 || fl != 1) begin
      n_fail++; $display("FAIL fwd_latency: fwd=%0d lat=%0d expected 1 1", fwd, fl);
    end
    n_checks++;
    if (fx != 10 || fy != 20 || fu != 3 || fv != 4) begin
      n_fail++; $display("FAIL fwd_coords: got %0d,%0d,%0d,%0d expected 10,20,3,4", fx, fy, fu, fv);
    end
    n_checks++;
    if (al != 5 || !one || !stb) begin
      n_fail++; $display("FAIL fwd_ack: lat=%0d single=%0d stable=%0d expected 5 1 1", al, one, stb);
    end
  endtask

  task automatic test_clip_boundary();
    int xs[6] = '{200, 99, 100, 199, 150, 150};
    int ys[6] = '{55, 55, 55, 59, 50, 60};
    bit fwd, one, stb, exp; int fx, fy, fu, fv, fl, al;
    for (int i = 0; i < 6; i++) begin
      set_cfg(1'b1, 100, 50, 200, 60, 640, 480);
      exp = inside_ref(xs[i], ys[i], 1'b1, 100, 50, 200, 60, 640, 480);
      run_pixel(xs[i], ys[i], i, i + 1, 0, 1'b0, fwd, fx, fy, fu, fv, fl, al, one, stb);
      n_checks++;
      if (fwd !== exp || al != (exp ? 2 : 1) || !one) begin
        n_fail++; $display("FAIL clip_edge x=%0d y=%0d: fwd=%0d ack_lat=%0d expected %0d %0d",
                           xs[i], ys[i], fwd, al, exp, exp ? 2 : 1);
      end
      if (exp) begin
        n_checks++;
        if (fx != xs[i] || fy != ys[i]) begin
          n_fail++; $display("FAIL clip_coords: got %0d,%0d expected %0d,%0d", fx, fy, xs[i], ys[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int got_x[$]; int acks = 0; int frags = 0; int x = 0; int last_ack = -1;
    set_cfg(1'b0, 0, 0, 0, 0, 640, 480);
    x_i = '0; y_i = PW'(7); u_i = '0; v_i = '0;
    write_i = 1'b1; frag_ack_i = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk_i); #1;
      if (frag_write_o === 1'b1) begin
        frags++; got_x.push_back(int'(frag_x_o));
      end
      if (ack_o === 1'b1) begin
        acks++; last_ack = cyc; x++;
        if (x == 8) write_i = 1'b0;
        else x_i = PW'(x);
      end
    end
    frag_ack_i = 1'b0; write_i = 1'b0;
    n_checks++;
    if (frags != 8 || acks != 8) begin
      n_fail++; $display("FAIL b2b_counts: frags=%0d acks=%0d expected 8 8", frags, acks);
    end
    n_checks++;
    if (last_ack != 23) begin
      n_fail++; $display("FAIL b2b_rate: last ack cycle %0d expected 23", last_ack);
    end
    for (int i = 0; i < got_x.size() && i < 8; i++) begin
      n_checks++;
      if (got_x[i] != i) begin
        n_fail++; $display("FAIL b2b_order: slot %0d got x=%0d expected %0d", i, got_x[i], i);
      end
    end
  endtask

  task automatic test_empty();
    bit fwd, one, stb; int fx, fy, fu, fv, fl, al;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_cfg(1'b1, 5, 0, 5, 100, 640, 480);
      else       set_cfg(1'b0, 0, 0, 0, 0, 0, 480);
      run_pixel(3 + (i % 4), 10, 0, 0, 0, 1'b0, fwd, fx, fy, fu, fv, fl, al, one, stb);
      n_checks++;
      if (fwd !== 1'b0 || al != 1 || !one) begin
        n_fail++; $display("FAIL empty_reject %0d: fwd=%0d ack_lat=%0d expected 0 1", i, fwd, al);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit fwd, one, stb; int fx, fy, fu, fv, fl, al; int stray = 0;
    set_cfg(1'b0, 0, 0, 0, 0, 640, 480);
    x_i = PW'(7); y_i = PW'(8); u_i = PW'(1); v_i = PW'(2);
    write_i = 1'b1; frag_ack_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (frag_write_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_enter_fwd: frag_write=%b busy=%b expected 1 1", frag_write_o, busy_o);
    end
    #2 rst_ni = 1'b0;
    write_i = 1'b0;
    #1;
    n_checks++;
    if ({ack_o, frag_write_o, busy_o} !== 3'b000 || {frag_x_o, frag_y_o} !== '0) begin
      n_fail++; $display("FAIL async_reset: ctrl=%b x=%0d y=%0d expected 000 0 0",
                         {ack_o, frag_write_o, busy_o}, frag_x_o, frag_y_o);
    end
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (ack_o !== 1'b0 || busy_o !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++; $display("FAIL stale_ack: %0d cycles with ack/busy expected 0", stray);
    end
    run_pixel(30, 40, 5, 6, 1, 1'b0, fwd, fx, fy, fu, fv, fl, al, one, stb);
    n_checks++;
    if (fwd !== 1'b1 || fx != 30 || fy != 40 || al != 3 || !one) begin
      n_fail++; $display("FAIL post_reset_pixel: fwd=%0d x=%0d y=%0d ack_lat=%0d expected 1 30 40 3",
                         fwd, fx, fy, al);
    end
  endtask

  task automatic test_random();
    bit fwd, one, stb, exp, en; int fx, fy, fu, fv, fl, al, d;
    int px, py, pu, pv, x0, y0, x1, y1, tx, ty;
    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom_range(0, 1));
      x0 = $urandom_range(0, 20); y0 = $urandom_range(0, 20);
      x1 = $urandom_range(0, 20); y1 = $urandom_range(0, 20);
      tx = $urandom_range(0, 20); ty = $urandom_range(0, 20);
      px = $urandom_range(0, 20); py = $urandom_range(0, 20);
      pu = $urandom_range(0, 65535); pv = $urandom_range(0, 65535);
      d  = $urandom_range(0, 3);
      set_cfg(en, x0, y0, x1, y1, tx, ty);
      exp = inside_ref(px, py, en, x0, y0, x1, y1, tx, ty);
      run_pixel(px, py, pu, pv, d, 1'b1, fwd, fx, fy, fu, fv, fl, al, one, stb);
      n_checks++;
      if (fwd !== exp || al != (exp ? d + 2 : 1) || !one) begin
        n_fail++; $display("FAIL rand_txn %0d (%0d,%0d): fwd=%0d ack_lat=%0d expected %0d %0d",
                           i, px, py, fwd, al, exp, exp ? d + 2 : 1);
      end
      if (exp) begin
        n_checks++;
        if (fx != px || fy != py || fu != pu || fv != pv || fl != 1 || !stb) begin
          n_fail++; $display("FAIL rand_frag %0d: got %0d,%0d,%0d,%0d lat=%0d stable=%0d expected %0d,%0d,%0d,%0d 1 1",
                             i, fx, fy, fu, fv, fl, stb, px, py, pu, pv);
        end
      end
    end
  endtask

`ifdef GFX_CLIP_STATS_EN
  task automatic test_stats();
    bit fwd, one, stb; int fx, fy, fu, fv, fl, al;
    set_cfg(1'b1, 100, 50, 200, 60, 640, 480);
    write_i = 1'b0; stats_clr_i = 1'b1;
    @(posedge clk_i); #1;
    stats_clr_i = 1'b0;
    n_checks++;
    if (pass_count_o !== 32'd0 || discard_count_o !== 32'd0) begin
      n_fail++; $display("FAIL stats_clear: got %0d/%0d expected 0/0", pass_count_o, discard_count_o);
    end
    for (int i = 0; i < 8; i++) begin
      run_pixel((i < 3) ? 120 + i : 300 + i, 55, 0, 0, 0, 1'b0, fwd, fx, fy, fu, fv, fl, al, one, stb);
    end
    n_checks++;
    if (pass_count_o !== 32'd3 || discard_count_o !== 32'd5) begin
      n_fail++; $display("FAIL stats_count: got %0d/%0d expected 3/5", pass_count_o, discard_count_o);
    end
    x_i = PW'(700); y_i = PW'(55); write_i = 1'b1; stats_clr_i = 1'b1;
    @(posedge clk_i); #1;
    stats_clr_i = 1'b0; write_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (pass_count_o !== 32'd0 || discard_count_o !== 32'd1) begin
      n_fail++; $display("FAIL stats_clr_inc: got %0d/%0d expected 0/1", pass_count_o, discard_count_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_clip_boundary();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_random();
`ifdef GFX_CLIP_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
